// File: rtl/prescaler_pkg.sv
// prescaler_pkg: shared defaults, channel-index width helper and channel state record
package prescaler_pkg;
    localparam int CNT_W_DEF = 14;
    localparam int NCH_DEF   = 4;
    localparam int DIV_W_DEF = 16;
    localparam int DIV_INIT_DEF = 0;

    typedef struct packed {
        logic [DIV_W_DEF-1:0] divisor;
        logic [DIV_W_DEF-1:0] shadow;
        logic [DIV_W_DEF-1:0] dc;
        logic                 pend;
    } chan_state_t;

    function automatic int ch_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/prescaler_chan.sv
// prescaler_chan: one programmable divider channel with shadowed divisor reload.
// Optional square-wave toggle output built only when PRESCALER_SQ_EN is defined.
module prescaler_chan
    import prescaler_pkg::*;
#(
    parameter int               DIV_W    = DIV_W_DEF,
    parameter logic [DIV_W-1:0] DIV_INIT = '0
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic             i_en,
    input  logic             i_clr,
    input  logic             i_wr,
    input  logic [DIV_W-1:0] i_val,
    output logic             o_tick,
    output logic             o_sq
);
    logic [DIV_W-1:0] r_div, r_shadow, r_dc;
    logic             r_pend, r_tick;
    logic             w_tc, w_rld;
    logic [DIV_W-1:0] w_next;

    assign w_tc   = i_en && (r_dc == '0);
    assign w_rld  = i_clr || w_tc;
    // A write landing on a reload edge only lands in the shadow; the reload uses the old value.
    assign w_next = r_pend ? r_shadow : r_div;

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_div    <= DIV_INIT;
            r_shadow <= DIV_INIT;
            r_dc     <= DIV_INIT;
            r_pend   <= 1'b0;
            r_tick   <= 1'b0;
        end else begin
            r_tick <= w_tc && !i_clr;
            if (w_rld) begin
                r_dc  <= w_next;
                r_div <= w_next;
            end else if (i_en) begin
                r_dc <= r_dc - 1'b1;
            end
            if (i_wr) begin
                r_shadow <= i_val;
                r_pend   <= 1'b1;
            end else if (w_rld) begin
                r_pend <= 1'b0;
            end
        end
    end

    assign o_tick = r_tick;

`ifdef PRESCALER_SQ_EN
    logic r_sq;
    always_ff @(posedge i_clk) begin
        if (!i_reset_n || i_clr) r_sq <= 1'b0;
        else if (w_tc)           r_sq <= ~r_sq;
    end
    assign o_sq = r_sq;
`else
    assign o_sq = 1'b0;
`endif
endmodule

// File: rtl/prescaler_bank.sv
// prescaler_bank: free-running tap counter plus NCH programmable tick dividers.
// Define PRESCALER_SQ_EN to build the per-channel square-wave outputs.
module prescaler_bank
    import prescaler_pkg::*;
#(
    parameter int               CNT_W    = CNT_W_DEF,
    parameter int               NCH      = NCH_DEF,
    parameter int               DIV_W    = DIV_W_DEF,
    parameter logic [DIV_W-1:0] DIV_INIT = DIV_W'(DIV_INIT_DEF),
    localparam int              CH_W     = ch_w(NCH)
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic             i_en,
    input  logic             i_clr,
    input  logic             i_div_wr,
    input  logic [CH_W-1:0]  i_div_ch,
    input  logic [DIV_W-1:0] i_div_val,
    output logic             o_div_ack,
    output logic [CNT_W-1:0] o_tap,
    output logic [NCH-1:0]   o_tick,
    output logic [NCH-1:0]   o_sq
);
    logic [CNT_W-1:0] r_tap;
    logic             r_ack;

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_tap <= '0;
            r_ack <= 1'b0;
        end else begin
            r_tap <= i_clr ? '0 : i_en ? r_tap + 1'b1 : r_tap;
            r_ack <= i_div_wr;
        end
    end

    assign o_tap     = r_tap;
    assign o_div_ack = r_ack;

    // Out-of-range channel indices match no channel, so the write is dropped but still acked.
    for (genvar c = 0; c < NCH; c++) begin : g_ch
        prescaler_chan #(.DIV_W(DIV_W), .DIV_INIT(DIV_INIT)) u_chan (
            .i_clk     (i_clk),
            .i_reset_n (i_reset_n),
            .i_en      (i_en),
            .i_clr     (i_clr),
            .i_wr      (i_div_wr && (32'(i_div_ch) == c)),
            .i_val     (i_div_val),
            .o_tick    (o_tick[c]),
            .o_sq      (o_sq[c])
        );
    end
endmodule
